// File: rtl/matmul_pkg.sv
// Shared types and constants for the 3x3 matrix-multiply controller.
package matmul_pkg;

   localparam int N             = 3;
   localparam int ELEMS         = 9;
   localparam int MAC_CYCLES    = 3;
   localparam int START_TIMEOUT = 15;

   typedef enum logic [2:0] {
      S_IDLE,
      S_CLR,
      S_LOADW,
      S_LOADX,
      S_WAIT_START,
      S_ROWCLR,
      S_MAC,
      S_DONE
   } state_e;

endpackage

// File: rtl/matmul_ctrl_if.sv
// Control/strobe bundle between the matmul controller and its host side.
interface matmul_ctrl_if;

   logic go;
   logic in_valid;
   logic start;
   logic abort;
   logic ldw;
   logic ldx;
   logic clear_mem;
   logic clear_mac;
   logic ld;
   logic unload1;
   logic unload2;
   logic unload3;
   logic busy;
   logic done;
   logic err;

   modport master (
      output go, in_valid, start, abort,
      input  ldw, ldx, clear_mem, clear_mac, ld,
      input  unload1, unload2, unload3, busy, done, err
   );

   modport slave (
      input  go, in_valid, start, abort,
      output ldw, ldx, clear_mem, clear_mac, ld,
      output unload1, unload2, unload3, busy, done, err
   );

endinterface

// File: rtl/matmul_ctrl_counter.sv
// Wrapping up-counter: counts 0..MAX on en, clr wins, tc flags MAX.
module mod_counter #(
   parameter int W   = 4,
   parameter int MAX = 8
) (
   input  logic clk,
   input  logic rst_n,
   input  logic en,
   input  logic clr,
   output logic tc
);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   assign tc = (cnt_q == W'(MAX));

   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (en) begin
         cnt_d = tc ? '0 : cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end

endmodule

// File: rtl/matmul_ctrl.sv
// Sequencer for load/clear/MAC/unload of a 3x3 matmul; no datapath.
module matmul_ctrl
   import matmul_pkg::*;
(
   input  logic          clk,
   input  logic          rst_n,
   matmul_ctrl_if.slave  bus
);

   state_e     state_q, state_d;
   logic [1:0] row_q, row_d;
   logic       err_q, err_d;

   logic loading;
   logic elem_en, elem_clr, elem_tc;
   logic k_en, k_clr, k_tc;
   logic to_en, to_clr, to_tc;

   assign loading  = (state_q == S_LOADW) || (state_q == S_LOADX);
   assign elem_en  = loading && bus.in_valid;
   assign elem_clr = bus.abort || !loading;
   assign k_en     = (state_q == S_MAC);
   assign k_clr    = bus.abort || !k_en;
   assign to_en    = (state_q == S_WAIT_START);
   assign to_clr   = bus.abort || !to_en || bus.start;

   mod_counter #(.W(4), .MAX(ELEMS - 1)) u_elem (
      .clk(clk), .rst_n(rst_n), .en(elem_en), .clr(elem_clr), .tc(elem_tc)
   );

   mod_counter #(.W(2), .MAX(MAC_CYCLES - 1)) u_k (
      .clk(clk), .rst_n(rst_n), .en(k_en), .clr(k_clr), .tc(k_tc)
   );

   mod_counter #(.W(4), .MAX(START_TIMEOUT - 1)) u_to (
      .clk(clk), .rst_n(rst_n), .en(to_en), .clr(to_clr), .tc(to_tc)
   );

   always_comb begin
      state_d = state_q;
      row_d   = row_q;
      err_d   = err_q;
      if (bus.abort) begin
         state_d = S_IDLE;
         row_d   = '0;
      end else begin
         unique case (state_q)
            S_IDLE: begin
               if (bus.go) begin
                  state_d = S_CLR;
                  err_d   = 1'b0;
               end
            end
            S_CLR:   state_d = S_LOADW;
            S_LOADW: if (elem_en && elem_tc) state_d = S_LOADX;
            S_LOADX: if (elem_en && elem_tc) state_d = S_WAIT_START;
            S_WAIT_START: begin
               if (bus.start) begin
                  state_d = S_ROWCLR;
                  row_d   = 2'd1;
               end else if (to_tc) begin
                  state_d = S_IDLE;
                  err_d   = 1'b1;
               end
            end
            S_ROWCLR: state_d = S_MAC;
            S_MAC: begin
               // k wraps on its own, so the next row starts at k=0
               if (k_tc) begin
                  if (row_q == 2'(N)) begin
                     state_d = S_DONE;
                  end else begin
                     state_d = S_ROWCLR;
                     row_d   = row_q + 2'd1;
                  end
               end
            end
            S_DONE: begin
               state_d = S_IDLE;
               row_d   = '0;
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         row_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         row_q   <= row_d;
         err_q   <= err_d;
      end
   end

   assign bus.ldw       = (state_q == S_LOADW) && bus.in_valid;
   assign bus.ldx       = (state_q == S_LOADX) && bus.in_valid;
   assign bus.clear_mem = (state_q == S_CLR);
   assign bus.clear_mac = (state_q == S_CLR) || (state_q == S_ROWCLR);
   assign bus.ld        = (state_q == S_MAC);
   assign bus.unload1   = (state_q == S_MAC) && (row_q == 2'd1);
   assign bus.unload2   = (state_q == S_MAC) && (row_q == 2'd2);
   assign bus.unload3   = (state_q == S_MAC) && (row_q == 2'd3);
   assign bus.busy      = (state_q != S_IDLE);
   assign bus.done      = (state_q == S_DONE);
   assign bus.err       = err_q;

endmodule

// File: doc/matmul_ctrl.md
MATMUL_CTRL -- requirements
Module: matmul_ctrl

Interface
REQ-001 clk  input  1  sole clock; all state updates on the rising edge.
REQ-002 rst_n  input  1  reset, asynchronous, active-low.
REQ-003 go  input  1  start request; sampled only in IDLE.
REQ-004 in_valid  input  1  data_in word present this cycle; sampled only in LOADW/LOADX.
REQ-005 start  input  1  memory bank ready flag (both matrices stored).
REQ-006 abort  input  1  synchronous cancel, any state.
REQ-007 ldw, ldx  output  1 each  write strobes to the memory bank.
REQ-008 clear_mem, clear_mac  output  1 each  clear strobes to the memory bank and the MAC array.
REQ-009 ld  output  1  MAC accumulate enable.
REQ-010 unload1, unload2, unload3  output  1 each  row-select strobes for rows 1..3; one-hot or all low.
REQ-011 busy  output  1  high in every state except IDLE.
REQ-012 done  output  1  one-cycle pulse on completion.
REQ-013 err  output  1  sticky start-timeout flag; cleared on the next accepted go.

Function
REQ-014 States SHALL be IDLE, CLR, LOADW, LOADX, WAIT_START, ROWCLR, MAC, DONE; outputs are Moore-decoded, except ldw and ldx, which are gated by in_valid.
REQ-015 IDLE: all strobes low; go=1 -> CLR next cycle; go in any other state is ignored.
REQ-016 CLR: clear_mem=1 and clear_mac=1 for exactly one cycle -> LOADW.
REQ-017 LOADW: ldw=in_valid; 4-bit elem counter increments per accepted word; the 9th accepted word (count 8) -> LOADX with the counter reset to 0.
REQ-018 LOADX: ldx=in_valid; same counting; the 9th word -> WAIT_START.
REQ-019 in_valid=0 stalls the load without a counter change; there is no upper limit on stall length.
REQ-020 WAIT_START: start=1 -> ROWCLR for row 1; a 4-bit timeout counter increments per cycle; 15 cycles without start -> err=1, IDLE.
REQ-021 ROWCLR: clear_mac=1 for one cycle -> MAC.
REQ-022 MAC: ld=1 and unload<row>=1 for exactly 3 cycles, tracked by a 2-bit k counter 0..2.
REQ-023 At k=2, the MAC state SHALL advance as follows: row<3 -> ROWCLR with row+1; row=3 -> DONE.
REQ-024 DONE: done=1 for one cycle -> IDLE.
REQ-025 abort=1 SHALL send any state to IDLE next cycle, clearing all counters; abort has priority over every other transition, including go; err is unchanged.
REQ-026 Nominal latency SHALL be 34 cycles, measured from the go-accept edge to the done pulse, with in_valid continuously high and start arriving 1 cycle after entering WAIT_START.

Reset
REQ-027 rst_n=0 SHALL immediately force IDLE, zero every counter, and drive every output low, including err.
REQ-028 Reset asserted mid-operation SHALL discard progress; a fresh go is then required.

Structure
REQ-029 Package matmul_pkg SHALL hold the state enum and the constants N=3, ELEMS=9, MAC_CYCLES=3 and START_TIMEOUT=15.
REQ-030 One sub-module, mod_counter (parameterised wrap value, enable, synchronous clear, terminal-count output), SHALL be instantiated for the element, k and timeout counters.
REQ-031 The block SHALL contain no datapath storage; data_in bypasses the controller straight to the memory bank.

Verification
REQ-032 Nominal case: go at cycle 0, in_valid held at 1, start at cycle 21 -> clear_mem at cycle 1; ldw cycles 2-10; ldx cycles 11-19; unload1 cycles 23-25, unload2 cycles 27-29, unload3 cycles 31-33; done at cycle 34.
REQ-033 Load stall: in_valid toggled 1,0,1,0... during LOADW -> exactly 9 ldw pulses, ldw never high while in_valid=0, LOADX entered after the 9th pulse.
REQ-034 Start timeout: start held at 0 after the loads -> err=1 and busy=0 on the 15th WAIT_START cycle; a following go clears err.
REQ-035 Abort during MAC (row 2, k=1) -> every strobe low the next cycle, busy=0, no done pulse; a new go replays the full sequence from CLR.
REQ-036 rst_n pulsed low mid-LOADX (element 5) -> outputs drop to 0 without waiting for clk; after release, go restarts at CLR with 9 new ldw pulses.
REQ-037 go asserted while busy, and go with abort in the same IDLE cycle -> both go requests ignored, with no state change.
